// File: rtl/aes_pkg.sv
// Shared AES definitions for the iterative encrypt and decrypt cores.
// Provides key_len encoding, round counts, FSM states, S-box and GF(2^8) helpers.
package aes_pkg;

  localparam logic [1:0] KL_INVALID = 2'b00;
  localparam logic [1:0] KL_128     = 2'b01;
  localparam logic [1:0] KL_192     = 2'b10;
  localparam logic [1:0] KL_256     = 2'b11;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } aes_state_e;

  localparam logic [7:0] SBOX_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] x);
    return xtime(x);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      KL_192:  return NR_192;
      KL_256:  return NR_256;
      default: return NR_128;
    endcase
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES cipher round: SubBytes, ShiftRows, MixColumns (bypassable), AddRoundKey.
// Byte i of the block sits at [127-8i -: 8]; i = 4*column + row.
module aes_enc_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         skip_mix,
  output logic [127:0] state_out
);

  logic [7:0]   sub_b [16];
  logic [7:0]   shf_b [16];
  logic [127:0] shf_w;
  logic [127:0] mix_w;

  // Row r of column c takes the byte from column (c + r) mod 4 of the same row.
  for (genvar gi = 0; gi < 16; gi++) begin : g_sub_shift
    assign sub_b[gi] = sbox(state_in[127-8*gi -: 8]);
    assign shf_b[gi] = sub_b[4*(((gi/4) + (gi%4)) % 4) + (gi%4)];
    assign shf_w[127-8*gi -: 8] = shf_b[gi];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = shf_b[4*gi];
    assign a1 = shf_b[4*gi+1];
    assign a2 = shf_b[4*gi+2];
    assign a3 = shf_b[4*gi+3];
    assign mix_w[127-32*gi -: 32] = {
      gf_mul2(a0) ^ gf_mul3(a1) ^ a2 ^ a3,
      a0 ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3,
      a0 ^ a1 ^ gf_mul2(a2) ^ gf_mul3(a3),
      gf_mul3(a0) ^ a1 ^ a2 ^ gf_mul2(a3)
    };
  end

  assign state_out = (skip_mix ? shf_w : mix_w) ^ round_key;

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128/192/256 encryption, one round per clock, round keys fetched by index.
// Optional AES_ENC_ABORT_EN adds an abort input that cancels an in-flight block.
module aes_encrypt_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [127:0] plaintext,
`ifdef AES_ENC_ABORT_EN
  input  logic         abort,
`endif
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         busy,
  output logic         ready,
  output logic [127:0] ciphertext
);

  aes_state_e   fsm_reg, fsm_next;
  logic [127:0] state_reg, state_next;
  logic [127:0] ciphertext_reg, ciphertext_next;
  logic [3:0]   round_reg, round_next;
  logic [3:0]   nr_reg, nr_next;
  logic         ready_reg, ready_next;
  logic         busy_reg, busy_next;
  logic [127:0] round_out;

  // The single round datapath serves both ROUND and FINAL; FINAL skips MixColumns.
  aes_enc_round u_round (
    .state_in  (state_reg),
    .round_key (rk),
    .skip_mix  (fsm_reg == ST_FINAL),
    .state_out (round_out)
  );

  always_comb begin
    fsm_next        = fsm_reg;
    state_next      = state_reg;
    ciphertext_next = ciphertext_reg;
    round_next      = round_reg;
    nr_next         = nr_reg;
    ready_next      = ready_reg;
    busy_next       = busy_reg;
    rk_idx          = 4'd0;
    case (fsm_reg)
      ST_IDLE, ST_DONE: begin
        if (start && key_len != KL_INVALID) begin
          state_next = plaintext ^ rk;
          nr_next    = nr_of(key_len);
          round_next = 4'd1;
          ready_next = 1'b0;
          busy_next  = 1'b1;
          fsm_next   = ST_ROUND;
        end
      end
      ST_ROUND: begin
        rk_idx     = round_reg;
        state_next = round_out;
        round_next = round_reg + 4'd1;
        if (round_reg == nr_reg - 4'd1) fsm_next = ST_FINAL;
      end
      ST_FINAL: begin
        rk_idx          = nr_reg;
        ciphertext_next = round_out;
        ready_next      = 1'b1;
        busy_next       = 1'b0;
        fsm_next        = ST_DONE;
      end
      default: fsm_next = ST_IDLE;
    endcase
`ifdef AES_ENC_ABORT_EN
    // Abort overrides FINAL completion, so ciphertext keeps the previous block.
    if (abort && (fsm_reg == ST_ROUND || fsm_reg == ST_FINAL)) begin
      fsm_next        = ST_IDLE;
      ciphertext_next = ciphertext_reg;
      ready_next      = 1'b0;
      busy_next       = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_reg        <= ST_IDLE;
      state_reg      <= '0;
      ciphertext_reg <= '0;
      round_reg      <= '0;
      nr_reg         <= '0;
      ready_reg      <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      fsm_reg        <= fsm_next;
      state_reg      <= state_next;
      ciphertext_reg <= ciphertext_next;
      round_reg      <= round_next;
      nr_reg         <= nr_next;
      ready_reg      <= ready_next;
      busy_reg       <= busy_next;
    end
  end

  assign busy       = busy_reg;
  assign ready      = ready_reg;
  assign ciphertext = ciphertext_reg;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Self-checking bench for aes_encrypt_iter: FIPS-197 vectors plus random blocks against
// a byte-level AES model whose S-box is derived from the GF(2^8) inverse and affine map.
module tb_aes_encrypt_iter;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   key_len;
  logic [127:0] plaintext;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         busy;
  logic         ready;
  logic [127:0] ciphertext;
`ifdef AES_ENC_ABORT_EN
  logic         abort = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] rk_tab [16];

  always #5 clk = ~clk;

  assign rk = rk_tab[rk_idx];

  aes_encrypt_iter dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .key_len    (key_len),
    .plaintext  (plaintext),
`ifdef AES_ENC_ABORT_EN
    .abort      (abort),
`endif
    .rk_idx     (rk_idx),
    .rk         (rk),
    .busy       (busy),
    .ready      (ready),
    .ciphertext (ciphertext)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  // Key expansion straight from the FIPS-197 word recurrence; key is left-aligned in 256 bits.
  task automatic load_key(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4*(nk+7); i++) begin
      if (i < nk) w[i] = key[255-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gmul(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) t = subword(t);
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r < 16; r++)
      rk_tab[r] = (r <= nk + 6) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [7:0]   a [4];
    logic [127:0] k;
    logic [127:0] res;
    k = rk_tab[0];
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int i = 0; i < 16; i++) u[i] = sbox_m[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = u[4*((c+r)%4)+r];
      if (rnd < nr)
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = s[4*c+r];
          for (int r = 0; r < 4; r++)
            s[4*c+r] = gmul(a[r], 8'h02) ^ gmul(a[(r+1)%4], 8'h03) ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
      k = rk_tab[rnd];
      for (int i = 0; i < 16; i++) s[i] ^= k[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge; edges are numbered from the accepting edge = 1.
  task automatic run_block(input logic [255:0] key, input logic [1:0] kl, input logic [127:0] pt,
                           input logic [127:0] exp_in, input bit use_model, input int pulse_at,
                           input string tag);
    int nr = 2*int'(kl) + 8;
    int n;
    logic [127:0] exp_ct;
    load_key(key, nr - 6);
    exp_ct = use_model ? model_encrypt(pt, nr) : exp_in;
    start = 1'b1; key_len = kl; plaintext = pt;
    check({tag, "/rk_idx_accept"}, 128'(rk_idx), 128'd0);
    @(negedge clk);
    start = 1'b0; key_len = 2'($urandom); plaintext = rand128();
    check({tag, "/ready_drop"}, 128'(ready), 128'd0);
    check({tag, "/busy_rise"}, 128'(busy), 128'd1);
    n = 1;
    while (ready !== 1'b1 && n < 40) begin
      check({tag, "/rk_idx"}, 128'(rk_idx), 128'(n));
      start = (n == pulse_at);
      if (n == pulse_at) key_len = KL_SEL(kl);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, "/latency"}, 128'(n), 128'(nr + 1));
    check({tag, "/ciphertext"}, ciphertext, exp_ct);
    check({tag, "/busy_end"}, 128'(busy), 128'd0);
    $display("block %s nr=%0d latency=%0d ct=%h", tag, nr, n, ciphertext);
  endtask

  function automatic logic [1:0] KL_SEL(input logic [1:0] kl);
    return kl;
  endfunction

  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; key_len = 2'b00; plaintext = '0;
    for (int r = 0; r < 16; r++) rk_tab[r] = '0;
    build_sbox();
    @(negedge clk);
    @(negedge clk);
    check("reset/busy", 128'(busy), 128'd0);
    check("reset/ready", 128'(ready), 128'd0);
    check("reset/rk_idx", 128'(rk_idx), 128'd0);
    check("reset/ciphertext", ciphertext, 128'd0);
    reset = 1'b0;
    @(negedge clk);

    // Invalid key length from IDLE is ignored.
    start = 1'b1; key_len = 2'b00; plaintext = PT;
    @(negedge clk);
    start = 1'b0;
    check("invalid_idle/busy", 128'(busy), 128'd0);
    check("invalid_idle/ready", 128'(ready), 128'd0);
    check("invalid_idle/rk_idx", 128'(rk_idx), 128'd0);
    $display("invalid key_len start in IDLE: busy=%0b ready=%0b", busy, ready);

    run_block(KEY128, 2'b01, PT, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, 5, "fips128");
    run_block(KEY192, 2'b10, PT, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 1'b0, 0, "fips192");
    run_block(KEY256, 2'b11, PT, CT256, 1'b0, 0, "fips256");

    // Invalid start in DONE leaves the result in place.
    start = 1'b1; key_len = 2'b00; plaintext = rand128();
    @(negedge clk);
    start = 1'b0;
    check("invalid_done/ready", 128'(ready), 128'd1);
    check("invalid_done/busy", 128'(busy), 128'd0);
    check("invalid_done/ciphertext", ciphertext, CT256);
    $display("invalid key_len start in DONE: ready=%0b", ready);

`ifdef AES_ENC_ABORT_EN
    load_key(KEY128, 4);
    start = 1'b1; key_len = 2'b01; plaintext = rand128();
    @(negedge clk);
    start = 1'b0;
    for (n = 1; n < 4; n++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort/busy", 128'(busy), 128'd0);
    check("abort/ready", 128'(ready), 128'd0);
    check("abort/rk_idx", 128'(rk_idx), 128'd0);
    check("abort/ciphertext", ciphertext, CT256);
    $display("abort at cycle 4: busy=%0b ready=%0b ct=%h", busy, ready, ciphertext);
`endif

    // Back-to-back random blocks, each started directly from DONE.
    for (int b = 0; b < 6; b++)
      run_block({rand128(), rand128()}, 2'(b % 3 + 1), rand128(), 128'h0, 1'b1, 0, "random");

    // Reset in the middle of an AES-256 block.
    load_key(KEY256, 8);
    start = 1'b1; key_len = 2'b11; plaintext = rand128();
    @(negedge clk);
    start = 1'b0;
    for (n = 1; n < 6; n++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset/busy", 128'(busy), 128'd0);
    check("midreset/ready", 128'(ready), 128'd0);
    check("midreset/rk_idx", 128'(rk_idx), 128'd0);
    check("midreset/ciphertext", ciphertext, 128'd0);
    $display("reset at cycle 6: busy=%0b ready=%0b ct=%h", busy, ready, ciphertext);
    reset = 1'b0;
    @(negedge clk);
    run_block(KEY256, 2'b11, PT, CT256, 1'b0, 0, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
